sp_xmit_ctrl: RTL

//  Read side of SP_fifo: drains one full frame of raw 16-bit ADC samples into Ethernet payloads.
//  The frame is 4096 samples, loaded by the write-side control.

---
 rtl/sp_xmit_ctrl.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/sp_xmit_ctrl.sv
// sp_xmit_ctrl: read side of SP_fifo.
// Waits for a full frame, then drains it as a burst of Ethernet payload packets.
// Each packet is a 4-byte sequence number (MSB first) followed by WORDS_PER_PKT
// 16-bit samples sent high byte first. Draining the fifo re-arms the write side.
// Ports:
//   clk, reset           clock, synchronous active-high reset
//   sp_fifo_rdfull       fifo full flag (starts a frame)
//   sp_fifo_rdempty      fifo empty flag (stalls the byte stream in DATA)
//   sp_fifo_q            fifo show-ahead data
//   sp_fifo_rdreq        pop pulse, issued when the low byte of a word is accepted
//   pkt_req / pkt_ack    Tx arbiter slot request / one-cycle grant
//   tx_data/valid/last   payload byte stream, tx_ready handshake
//   seq_num              sequence number of the next packet
//   busy                 frame in progress
module sp_xmit_ctrl #(
  parameter int unsigned SAMPLES_PER_FRAME = 4096,
  parameter int unsigned WORDS_PER_PKT     = 256,
  parameter int unsigned SEQ_WIDTH         = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 sp_fifo_rdfull,
  input  logic                 sp_fifo_rdempty,
  input  logic [15:0]          sp_fifo_q,
  output logic                 sp_fifo_rdreq,
  output logic                 pkt_req,
  input  logic                 pkt_ack,
  output logic [7:0]           tx_data,
  output logic                 tx_valid,
  output logic                 tx_last,
  input  logic                 tx_ready,
  output logic [SEQ_WIDTH-1:0] seq_num,
  output logic                 busy
);

  localparam int unsigned PKTS_PER_FRAME = SAMPLES_PER_FRAME / WORDS_PER_PKT;
  localparam int unsigned WORD_W = (WORDS_PER_PKT > 1) ? $clog2(WORDS_PER_PKT) : 1;
  localparam int unsigned PKT_W  = (PKTS_PER_FRAME > 1) ? $clog2(PKTS_PER_FRAME) : 1;
  localparam logic [WORD_W-1:0] LAST_WORD = WORD_W'(WORDS_PER_PKT - 1);
  localparam logic [PKT_W-1:0]  LAST_PKT  = PKT_W'(PKTS_PER_FRAME - 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    WAIT_FULL = 3'd1,
    REQ       = 3'd2,
    HDR       = 3'd3,
    DATA      = 3'd4,
    DONE      = 3'd5
  } state_t;

  state_t               state_q, state_d;
  logic [1:0]           byte_sel_q, byte_sel_d;
  logic                 lo_q, lo_d;           // 1: low byte of current word is on tx_data
  logic [WORD_W-1:0]    word_q, word_d;
  logic [PKT_W-1:0]     pkt_q, pkt_d;
  logic [SEQ_WIDTH-1:0] seq_q, seq_d;
  logic                 pkt_req_q, busy_q;
  logic [31:0]          hdr_word;

  assign hdr_word = 32'(seq_q);
  assign seq_num  = seq_q;
  assign pkt_req  = pkt_req_q;
  assign busy     = busy_q;

  // State and counter registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      byte_sel_q <= '0;
      lo_q       <= 1'b0;
      word_q     <= '0;
      pkt_q      <= '0;
      seq_q      <= '0;
      pkt_req_q  <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      byte_sel_q <= byte_sel_d;
      lo_q       <= lo_d;
      word_q     <= word_d;
      pkt_q      <= pkt_d;
      seq_q      <= seq_d;
      // Request and busy are registered decodes of the upcoming state
      pkt_req_q  <= (state_d == REQ);
      busy_q     <= (state_d == REQ) || (state_d == HDR) || (state_d == DATA);
    end
  end

  // Next-state, counters and byte-stream outputs
  always_comb begin
    state_d       = state_q;
    byte_sel_d    = byte_sel_q;
    lo_d          = lo_q;
    word_d        = word_q;
    pkt_d         = pkt_q;
    seq_d         = seq_q;
    tx_valid      = 1'b0;
    tx_data       = 8'h00;
    tx_last       = 1'b0;
    sp_fifo_rdreq = 1'b0;

    unique case (state_q)
      IDLE: state_d = WAIT_FULL;

      WAIT_FULL: begin
        if (sp_fifo_rdfull) begin
          state_d = REQ;
          word_d  = '0;
          pkt_d   = '0;
        end
      end

      REQ: begin
        if (pkt_ack) begin
          state_d    = HDR;
          byte_sel_d = 2'd0;
        end
      end

      HDR: begin
        tx_valid = 1'b1;
        unique case (byte_sel_q)
          2'd0:    tx_data = hdr_word[31:24];
          2'd1:    tx_data = hdr_word[23:16];
          2'd2:    tx_data = hdr_word[15:8];
          default: tx_data = hdr_word[7:0];
        endcase
        if (tx_ready) begin
          byte_sel_d = byte_sel_q + 2'd1;
          if (byte_sel_q == 2'd3) begin
            state_d = DATA;
            lo_d    = 1'b0;
            word_d  = '0;
          end
        end
      end

      DATA: begin
        // An empty fifo stalls the stream without consuming anything
        tx_valid = !sp_fifo_rdempty;
        tx_data  = lo_q ? sp_fifo_q[7:0] : sp_fifo_q[15:8];
        tx_last  = tx_valid && lo_q && (word_q == LAST_WORD);
        if (tx_valid && tx_ready) begin
          if (!lo_q) begin
            lo_d = 1'b1;
          end else begin
            lo_d          = 1'b0;
            sp_fifo_rdreq = 1'b1;
            word_d        = word_q + WORD_W'(1);
            if (word_q == LAST_WORD) begin
              word_d  = '0;
              seq_d   = seq_q + SEQ_WIDTH'(1);
              pkt_d   = pkt_q + PKT_W'(1);
              state_d = (pkt_q == LAST_PKT) ? DONE : REQ;
            end
          end
        end
      end

      DONE: state_d = WAIT_FULL;

      default: state_d = IDLE;
    endcase
  end

endmodule
